v13_peak_detector: RTL

V13_PEAK_DETECTOR -- requirements
Module: v13_peak_detector

---
 rtl/package_settings.sv | 4 +
 rtl/v13_peak_detector_pkg.sv | 15 +
 rtl/v13_event_reg.sv | 60 ++++++
 rtl/v13_peak_detector.sv | 122 ++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// Project-wide sample format shared by the filter chain and downstream blocks.
package package_settings;
  localparam int SIZE_FILTER_DATA = 15;
endpackage

// File: rtl/v13_peak_detector_pkg.sv
// Peak detector defaults, FSM state encoding and a shared saturating counter helper.
package v13_peakdet_parameters;
  localparam int HOLDOFF_DEF  = 8;
  localparam int TS_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/v13_event_reg.sv
// Single-entry valid/ready event register; events arriving while full are counted and dropped.
module v13_event_reg
  import package_settings::*;
  import v13_peakdet_parameters::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic signed [SIZE_FILTER_DATA:0] amp_i,
  input  logic [TS_WIDTH-1:0]           time_i,
  input  logic [7:0]                    width_i,
  input  logic                          pileup_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic signed [SIZE_FILTER_DATA:0] amp_o,
  output logic [TS_WIDTH-1:0]           time_o,
  output logic [7:0]                    width_o,
  output logic                          pileup_o,
  output logic [7:0]                    lost_o
);
  logic                           valid_q;
  logic signed [SIZE_FILTER_DATA:0] amp_q;
  logic [TS_WIDTH-1:0]            time_q;
  logic [7:0]                     width_q;
  logic                           pileup_q;
  logic [7:0]                     lost_q;
  logic                           can_load;

  // A slot is free if empty or being emptied by a transfer this same cycle.
  assign can_load = !valid_q || ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      amp_q    <= '0;
      time_q   <= '0;
      width_q  <= '0;
      pileup_q <= 1'b0;
      lost_q   <= '0;
    end else if (load_i && can_load) begin
      valid_q  <= 1'b1;
      amp_q    <= amp_i;
      time_q   <= time_i;
      width_q  <= width_i;
      pileup_q <= pileup_i;
    end else begin
      if (load_i) lost_q <= sat_inc8(lost_q);
      if (valid_q && ready_i) valid_q <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign amp_o    = amp_q;
  assign time_o   = time_q;
  assign width_o  = width_q;
  assign pileup_o = pileup_q;
  assign lost_o   = lost_q;
endmodule

// File: rtl/v13_peak_detector.sv
// Threshold-crossing peak detector: tracks pulse maximum, its timestamp, width and pile-up,
// then enforces a hold-off dead time before re-arming.
module v13_peak_detector
  import package_settings::*;
  import v13_peakdet_parameters::*;
#(
  parameter int HOLDOFF  = HOLDOFF_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [SIZE_FILTER_DATA:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA:0] threshold,
  input  logic                             event_ready,
  output logic                             event_valid,
  output logic signed [SIZE_FILTER_DATA:0] event_amplitude,
  output logic [TS_WIDTH-1:0]              event_time,
  output logic [7:0]                       event_width,
  output logic                             event_pileup,
  output logic [7:0]                       lost_count,
  output logic                             busy
);
  localparam int CNT_W = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF - 1);

  state_e                           state_q, state_d;
  logic [TS_WIDTH-1:0]              ts_q;
  logic signed [SIZE_FILTER_DATA:0] max_q;
  logic [TS_WIDTH-1:0]              max_time_q;
  logic [7:0]                       width_q;
  logic                             falling_q;
  logic                             pileup_q;
  logic signed [SIZE_FILTER_DATA:0] prev_q;
  logic [CNT_W-1:0]                 hold_cnt_q;
  logic                             above;
  logic                             evt_load;

  assign above = filter_data > threshold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (above) state_d = ST_RISE;
      ST_RISE: if (!above) state_d = ST_HOLD;
      ST_HOLD: if (!above && hold_cnt_q == CNT_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    evt_load = (state_q == ST_RISE) && !above;
  end

  // Pulse datapath; prev_q always follows the input so slope tracking starts on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      max_q      <= '0;
      max_time_q <= '0;
      width_q    <= '0;
      falling_q  <= 1'b0;
      pileup_q   <= 1'b0;
      prev_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      ts_q   <= ts_q + TS_WIDTH'(1);
      prev_q <= filter_data;
      case (state_q)
        ST_IDLE: begin
          if (above) begin
            max_q      <= filter_data;
            max_time_q <= ts_q;
            width_q    <= 8'd1;
            falling_q  <= 1'b0;
            pileup_q   <= 1'b0;
          end
        end
        ST_RISE: begin
          if (above) begin
            width_q <= sat_inc8(width_q);
            if (filter_data > max_q) begin
              max_q      <= filter_data;
              max_time_q <= ts_q;
            end
            if (filter_data < prev_q) falling_q <= 1'b1;
            if (filter_data > prev_q && falling_q) pileup_q <= 1'b1;
          end else begin
            hold_cnt_q <= '0;
          end
        end
        ST_HOLD: begin
          if (above) hold_cnt_q <= '0;
          else       hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
        default: hold_cnt_q <= '0;
      endcase
    end
  end

  v13_event_reg #(.TS_WIDTH(TS_WIDTH)) u_event_reg (
    .clk      (clk),
    .reset    (reset),
    .load_i   (evt_load),
    .amp_i    (max_q),
    .time_i   (max_time_q),
    .width_i  (width_q),
    .pileup_i (pileup_q),
    .ready_i  (event_ready),
    .valid_o  (event_valid),
    .amp_o    (event_amplitude),
    .time_o   (event_time),
    .width_o  (event_width),
    .pileup_o (event_pileup),
    .lost_o   (lost_count)
  );
endmodule
